magcmp_serial: RTL and testbench

//  Parametrised, multi-cycle magnitude comparator; successor to the fixed 4-bit combinational compare.

---
 rtl/magcmp_pkg.sv | 23 ++
 rtl/magcmp_digit.sv | 26 ++
 rtl/magcmp_serial.sv | 126 ++++++++++++
 tb/tb_magcmp_serial.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/magcmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package magcmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Internal result encoding; RES_NONE means no decision reached yet.
   localparam logic [1:0] RES_NONE = 2'd0;
   localparam logic [1:0] RES_GT   = 2'd1;
   localparam logic [1:0] RES_EQ   = 2'd2;
   localparam logic [1:0] RES_LT   = 2'd3;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/magcmp_digit.sv
// Combinational DIGIT-bit compare; invert_msb flips the sign bit so a
// two's-complement top digit orders correctly under an unsigned compare.
module magcmp_digit #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             invert_msb,
   output logic             gt_d,
   output logic             eq_d
);

   logic [DIGIT-1:0] a_x;
   logic [DIGIT-1:0] b_x;

   always_comb begin
      a_x            = a_d;
      b_x            = b_d;
      a_x[DIGIT-1]   = a_d[DIGIT-1] ^ invert_msb;
      b_x[DIGIT-1]   = b_d[DIGIT-1] ^ invert_msb;
   end

   assign gt_d = (a_x > b_x);
   assign eq_d = (a_x == b_x);

endmodule

// File: rtl/magcmp_serial.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle.
// Optional: define MAGCMP_EARLY_EXIT_EN to finish on the first differing digit.
module magcmp_serial
   import magcmp_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGIT  = 4,
   parameter int unsigned SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned IDXW = (NDIG > 1) ? clog2(NDIG) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [IDXW-1:0]  idx;
   logic [1:0]       res;
   logic [1:0]       res_nxt;
   logic             accept;
   logic             last;
   logic             invert;
   logic             gt_d;
   logic             eq_d;

   assign last   = (idx == IDXW'(NDIG - 1));
   assign invert = (SIGNED != 0) && (idx == '0);

   magcmp_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d       (sh_a[WIDTH-1 -: DIGIT]),
      .b_d       (sh_b[WIDTH-1 -: DIGIT]),
      .invert_msb(invert),
      .gt_d      (gt_d),
      .eq_d      (eq_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state; res freezes at the first decision and later digits leave it alone.
   always_comb begin
      state_nxt = state;
      res_nxt   = res;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (res == RES_NONE) begin
               if (!eq_d)     res_nxt = gt_d ? RES_GT : RES_LT;
               else if (last) res_nxt = RES_EQ;
            end
`ifdef MAGCMP_EARLY_EXIT_EN
            if (!eq_d || last) state_nxt = DONE;
`else
            if (last) state_nxt = DONE;
`endif
         end
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (accept) res_nxt = RES_NONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a <= '0;
         sh_b <= '0;
         idx  <= '0;
         res  <= RES_NONE;
         busy <= 1'b0;
         done <= 1'b0;
         gt   <= 1'b0;
         eq   <= 1'b0;
         lt   <= 1'b0;
      end else begin
         busy <= (state_nxt == RUN);
         done <= (state_nxt == DONE);
         res  <= res_nxt;
         if (accept) begin
            sh_a <= a;
            sh_b <= b;
            idx  <= '0;
            gt   <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
         end else if (state == RUN) begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            idx  <= idx + IDXW'(1);
            // Visible result changes only on the edge that enters DONE.
            if (state_nxt == DONE) begin
               gt <= (res_nxt == RES_GT);
               eq <= (res_nxt == RES_EQ);
               lt <= (res_nxt == RES_LT);
            end
         end
      end
   end

endmodule

// File: tb/tb_magcmp_serial.sv
// Bench for magcmp_serial: four configurations (unsigned/signed DIGIT=4, DIGIT=1, DIGIT=16).
// Timing expectations follow MAGCMP_EARLY_EXIT_EN when defined.
module tb_magcmp_serial;

   typedef struct {
      int         unit;
      logic [2:0] res;
      int         cyc;
   } exp_t;

   typedef struct {
      int          unit;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  res;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  start_v;
   logic [15:0] a_v [4];
   logic [15:0] b_v [4];
   logic [3:0]  busy_v, done_v, gt_v, eq_v, lt_v;

   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   exp_t sbq[$];
   vec_t tbl[13];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   magcmp_serial #(.WIDTH(16), .DIGIT(4), .SIGNED(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]));
   magcmp_serial #(.WIDTH(16), .DIGIT(4), .SIGNED(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]));
   magcmp_serial #(.WIDTH(16), .DIGIT(1), .SIGNED(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]));
   magcmp_serial #(.WIDTH(16), .DIGIT(16), .SIGNED(0)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]),
      .busy(busy_v[3]), .done(done_v[3]), .gt(gt_v[3]), .eq(eq_v[3]), .lt(lt_v[3]));

   function automatic int dig_of(input int u);
      if (u == 2) return 1;
      if (u == 3) return 16;
      return 4;
   endfunction

   // Reference compare, returns {gt,eq,lt}.
   function automatic logic [2:0] model(input int u, input logic [15:0] x, input logic [15:0] y);
      if (u == 1) begin
         if ($signed(x) > $signed(y)) return 3'b100;
         if ($signed(x) < $signed(y)) return 3'b001;
         return 3'b010;
      end
      if (x > y) return 3'b100;
      if (x < y) return 3'b001;
      return 3'b010;
   endfunction

   function automatic int lat_of(input int u, input logic [15:0] x, input logic [15:0] y);
      int d;
      int nd;
      d  = dig_of(u);
      nd = 16 / d;
`ifdef MAGCMP_EARLY_EXIT_EN
      for (int i = 0; i < nd; i++) begin
         logic [15:0] xs;
         logic [15:0] ys;
         xs = (x << (i * d)) >> (16 - d);
         ys = (y << (i * d)) >> (16 - d);
         if (xs != ys) return i + 1;
      end
`endif
      return nd;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   // Advance to the next falling edge and retire any done pulses against the scoreboard.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
         if (done_v[u]) begin
            if (sbq.size() == 0) begin
               chk($sformatf("spurious_done_u%0d", u), 32'(done_v[u]), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk($sformatf("done_unit_u%0d", u), 32'(u), 32'(e.unit));
               chk($sformatf("result_u%0d", u), 32'({gt_v[u], eq_v[u], lt_v[u]}), 32'(e.res));
               chk($sformatf("done_cycle_u%0d", u), 32'(cyc), 32'(e.cyc));
            end
         end
      end
   endtask

   task automatic wait_done(input int u, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (done_v[u]) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic run_one(input int u, input logic [15:0] x, input logic [15:0] y,
                          input logic [2:0] expv);
      int  lat;
      int  nb;
      bit  seen;
      lat = lat_of(u, x, y);
      tick();
      a_v[u]     = x;
      b_v[u]     = y;
      start_v[u] = 1'b1;
      sbq.push_back('{u, expv, cyc + 1 + lat});
      tick();
      start_v[u] = 1'b0;
      chk($sformatf("busy_after_accept_u%0d", u), 32'(busy_v[u]), 32'd1);
      chk($sformatf("cleared_u%0d", u), 32'({gt_v[u], eq_v[u], lt_v[u]}), 32'd0);
      nb   = 0;
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (done_v[u]) begin
            seen = 1'b1;
            break;
         end
         if (busy_v[u]) nb++;
         tick();
      end
      chk($sformatf("done_seen_u%0d", u), 32'(seen), 32'd1);
      chk($sformatf("busy_cycles_u%0d", u), 32'(nb), 32'(lat));
   endtask

   initial begin
      logic [15:0] x;
      logic [15:0] y;
      int          cnt;

      tbl[0]  = '{0, 16'h1234, 16'h1234, 3'b010};
      tbl[1]  = '{0, 16'h8000, 16'h7FFF, 3'b100};
      tbl[2]  = '{1, 16'h8000, 16'h7FFF, 3'b001};
      tbl[3]  = '{0, 16'h5000, 16'h4FFF, 3'b100};
      tbl[4]  = '{0, 16'h0000, 16'hFFFF, 3'b001};
      tbl[5]  = '{1, 16'hFFFF, 16'h0001, 3'b001};
      tbl[6]  = '{1, 16'h7FFF, 16'h8000, 3'b100};
      tbl[7]  = '{1, 16'hFFFE, 16'hFFFF, 3'b001};
      tbl[8]  = '{2, 16'h1234, 16'h1234, 3'b010};
      tbl[9]  = '{2, 16'h0001, 16'h0000, 3'b100};
      tbl[10] = '{3, 16'hABCD, 16'hABCE, 3'b001};
      tbl[11] = '{3, 16'hFFFF, 16'hFFFF, 3'b010};
      tbl[12] = '{0, 16'h0000, 16'h0000, 3'b010};

      rst_n   = 1'b0;
      start_v = '0;
      for (int u = 0; u < 4; u++) begin
         a_v[u] = '0;
         b_v[u] = '0;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 4; u++)
         chk($sformatf("reset_outputs_u%0d", u),
             32'({busy_v[u], done_v[u], gt_v[u], eq_v[u], lt_v[u]}), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 13; i++)
         run_one(tbl[i].unit, tbl[i].a, tbl[i].b, tbl[i].res);

      // start pulses with new operands while busy are ignored
      tick();
      a_v[0] = 16'h00F0; b_v[0] = 16'h00F1; start_v[0] = 1'b1;
      sbq.push_back('{0, 3'b001, cyc + 1 + lat_of(0, 16'h00F0, 16'h00F1)});
      tick();
      a_v[0] = 16'hFFFF; b_v[0] = 16'h0000;
      tick();
      a_v[0] = 16'h0000; b_v[0] = 16'hFFFF;
      tick();
      start_v[0] = 1'b0;
      wait_done(0, "ignore_busy_done");
      repeat (6) tick();
      chk("ignore_busy_queue_empty", 32'(sbq.size()), 32'd0);

      // back-to-back: start held through the DONE cycle
      tick();
      a_v[0] = 16'h0001; b_v[0] = 16'h0002; start_v[0] = 1'b1;
      sbq.push_back('{0, 3'b001, cyc + 1 + lat_of(0, 16'h0001, 16'h0002)});
      tick();
      a_v[0] = 16'hFFFF; b_v[0] = 16'h0000;
      wait_done(0, "b2b_first_done");
      sbq.push_back('{0, 3'b100, cyc + 1 + lat_of(0, 16'hFFFF, 16'h0000)});
      tick();
      start_v[0] = 1'b0;
      chk("b2b_busy", 32'(busy_v[0]), 32'd1);
      chk("b2b_done_drop", 32'(done_v[0]), 32'd0);
      chk("b2b_cleared", 32'({gt_v[0], eq_v[0], lt_v[0]}), 32'd0);
      wait_done(0, "b2b_second_done");

      // reset in the middle of a compare
      tick();
      a_v[0] = 16'h1111; b_v[0] = 16'h1111; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_outputs",
          32'({busy_v[0], done_v[0], gt_v[0], eq_v[0], lt_v[0]}), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done_v[0]) cnt++;
      end
      chk("no_done_after_reset", 32'(cnt), 32'd0);
      chk("idle_after_reset", 32'(busy_v[0]), 32'd0);

      // random operands against the reference model, every configuration
      for (int i = 0; i < 12; i++) begin
         for (int u = 0; u < 4; u++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 4 == 0) y = x;
            if (i % 4 == 1) y = x ^ 16'h0001;
            run_one(u, x, y, model(u, x, y));
         end
      end
      repeat (4) tick();
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
